p2s_stream: RTL and testbench
=============================

// Module: p2s_stream
// PURPOSE
//  Parametrised parallel-to-serial converter with valid/ready input and tick-paced output.
//  - Accepts DATA_W-bit words through a 1-entry holding register.
//  - Shifts each word out MSB- or LSB-first, one bit per tick.
//  - Optional idle gap between frames; frame-start/last markers for downstream framing logic.
//  Sits between a word-producing datapath and a serial line driver / bit-level encoder.
// PARAMETERS
//  DATA_W      8   word width; legal range 2..64
//  MSB_FIRST   1   1: bit DATA_W-1 first; 0: bit 0 first
//  GAP_TICKS   0   idle tick slots inserted after each frame; legal range 0..255
//  IDLE_LEVEL  0   value driven on ser_out when no bit is being sent
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst          in   1       synchronous reset, active high
//  tick         in   1       bit-rate strobe; tie to 1 for one bit per clk
//  in_valid     in   1       in_data valid
//  in_ready     out  1       holding register empty; word accepted when in_valid & in_ready
//  in_data      in   DATA_W  parallel word
//  ser_out      out  1       serial data, registered
//  ser_en       out  1       1-cycle pulse: ser_out carries a new bit this cycle
//  frame_start  out  1       pulse with ser_en on the first bit of a word
//  frame_last   out  1       pulse with ser_en on the last bit of a word
//  busy         out  1       state != IDLE or holding register full
// BEHAVIOUR
//  Reset (rst=1 at clk edge)
//   - state=IDLE, hold_vld=0, bit/gap counters=0.
//   - ser_out=IDLE_LEVEL, ser_en=frame_start=frame_last=0, busy=0.
//   - Reset mid-frame drops the current word and the held word; no partial bits resume.
//  Input handshake
//   - in_ready = ~hold_vld (combinational from the register).
//   - Accept sets hold_vld and captures in_data.
//   - hold_vld clears when the word moves to the shifter.
//   - No accept and pop on the same cycle, because in_ready=0 whenever a pop is possible.
//  FSM, advances only on cycles with tick=1; with tick=0 all state holds and ser_en/frame_* are 0
//   - IDLE
//     - hold_vld=1: load shreg from hold and pop it; emit the first bit with frame_start=1;
//       set bit_cnt=1; go to SHIFT.
//     - Otherwise: ser_out=IDLE_LEVEL.
//   - SHIFT
//     - Emit the next bit; bit_cnt++.
//     - At bit_cnt==DATA_W-1 this is the last bit: frame_last=1; go to GAP if GAP_TICKS>0, else IDLE.
//   - GAP
//     - ser_out=IDLE_LEVEL, ser_en=0; gap_cnt++.
//     - After GAP_TICKS ticks, gap_cnt=0 and go to IDLE.
//  Timing
//   - Back-to-back words with GAP_TICKS=0 and tick=1 produce a continuous bitstream;
//     last bit of word N is immediately followed by first bit of word N+1.
//   - Latency: word accepted at edge k; with tick=1, first bit is registered at edge k+1
//     and visible with ser_en in cycle k+1.
//   - Between bits, ser_out holds the last emitted bit until the next tick.
//  Bit order
//   - MSB_FIRST=1: emit shreg[DATA_W-1], shift left.
//   - MSB_FIRST=0: emit shreg[0], shift right.
//  Counters
//   - bit_cnt width $clog2(DATA_W); gap_cnt width 8.
//   - Neither counter wraps; both reset to 0 on frame or gap end.
// STRUCTURE
//  p2s_pkg: state encodings ST_IDLE/ST_SHIFT/ST_GAP (2-bit localparams) and shared
//   helper function for counter width; reused by future s2p_stream.
//  Sub-module p2s_hold_reg: 1-entry valid/ready holding register (push, pop, hold_vld, data).
//  Top: FSM, shift register, counters, output registers.
// TESTING
//  1. DATA_W=8, MSB_FIRST=1, tick=1, in_data=8'hA5 once
//     -> ser_en high 8 cycles, ser_out 1,0,1,0,0,1,0,1;
//        frame_start on bit 0, frame_last on bit 7; then ser_out=IDLE_LEVEL, busy=0.
//  2. MSB_FIRST=0, 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 reversed per bit index (LSB first: 1,0,1,0,0,1,0,1).
//     Use 8'h01 to discriminate: LSB-first gives 1 then seven 0s.
//  3. GAP_TICKS=0, in_valid held with 8'hFF then 8'h00
//     -> 16 consecutive ser_en pulses, 8 ones then 8 zeros; in_ready re-asserts 1 cycle after each pop.
//  4. GAP_TICKS=3, two words back-to-back -> exactly 3 ticks with ser_en=0 between frame_last and next frame_start.
//  5. tick every 4th clk, 8'hC3 -> ser_en pulses only on tick cycles, 32 clks per frame; ser_out stable between ticks.
//  6. rst asserted after bit 3 with a word held
//     -> next cycle all outputs at reset values, in_ready=1; new word restarts from frame_start.

Source files
------------

// File: rtl/p2s_pkg.sv
// Definitions shared by the serial stream converters (p2s_stream now, s2p_stream later).
package p2s_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int GAP_CNT_W = 8;

    // Width of a counter indexing an n-bit word; at least one bit so DATA_W=2 stays legal.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p2s_stream_if.sv
// Word-side valid/ready channel feeding the parallel-to-serial converter.
interface p2s_stream_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/p2s_hold_reg.sv
// One-entry holding register between the word producer and the shifter.
module p2s_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              hold_vld,
    output logic [DATA_W-1:0] hold_data
);

    // push and pop never coincide: the producer only sees ready while the entry is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (push) begin
            hold_vld  <= 1'b1;
            hold_data <= push_data;
        end else if (pop) begin
            hold_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter: valid/ready word input, tick-paced serial output with framing.
//
// state    | meaning
// ST_IDLE  | no word in flight; start a frame on the next tick if a word is held
// ST_SHIFT | emitting bits 1..DATA_W-1 of the current word, one per tick
// ST_GAP   | inter-frame idle slots, GAP_TICKS ticks long
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_TICKS  = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    p2s_stream_if.slave in_if,
    output logic        ser_out,
    output logic        ser_en,
    output logic        frame_start,
    output logic        frame_last,
    output logic        busy
);

    localparam int                     BIT_W    = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0]       BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_CNT_W-1:0]   GAP_LAST = (GAP_TICKS > 0) ? GAP_CNT_W'(GAP_TICKS - 1) : '0;

    logic [1:0]           state;
    logic [DATA_W-1:0]    shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 hold_vld;
    logic [DATA_W-1:0]    hold_data;
    logic                 push;
    logic                 pop;

    function automatic logic next_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    assign push            = in_if.in_valid & ~hold_vld;
    assign pop             = tick & (state == ST_IDLE) & hold_vld;
    assign in_if.in_ready  = ~hold_vld;
    assign busy            = (state != ST_IDLE) | hold_vld;

    p2s_hold_reg #(
        .DATA_W    (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_if.in_data),
        .pop       (pop),
        .hold_vld  (hold_vld),
        .hold_data (hold_data)
    );

    // The shifter is pre-shifted on load so every state emits from the same end of shreg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            ser_out     <= IDLE_LEVEL;
            ser_en      <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            ser_en      <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (hold_vld) begin
                            ser_out     <= next_bit(hold_data);
                            shreg       <= shift_once(hold_data);
                            ser_en      <= 1'b1;
                            frame_start <= 1'b1;
                            bit_cnt     <= BIT_W'(1);
                            state       <= ST_SHIFT;
                        end else begin
                            ser_out     <= IDLE_LEVEL;
                        end
                    end
                    ST_SHIFT: begin
                        ser_out <= next_bit(shreg);
                        shreg   <= shift_once(shreg);
                        ser_en  <= 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            frame_last <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        ser_out <= IDLE_LEVEL;
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        ser_out <= IDLE_LEVEL;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p2s_stream.sv
// Directed bench for p2s_stream: three instances cover MSB/LSB order, idle level and gap slots.
module tb_p2s_stream;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    int              tick_div = 1;
    int              tick_ph;
    logic [2:0]      vld;
    logic [DW-1:0]   dat [3];
    wire  [2:0]      so, en, fs, fl, bsy, rdy;
    logic [2:0]      idle_lvl = 3'b010;

    int              n_chk;
    int              n_fail;

    int              cap_n;
    logic [63:0]     cap_bits, cap_fs, cap_fl, cap_rdyfs;
    int              cap_cyc [64];
    int              cap_unstable;

    always #5 clk = ~clk;

    p2s_stream_if #(.DATA_W(DW)) if_a ();
    p2s_stream_if #(.DATA_W(DW)) if_b ();
    p2s_stream_if #(.DATA_W(DW)) if_c ();

    assign if_a.in_valid = vld[0];
    assign if_a.in_data  = dat[0];
    assign rdy[0]        = if_a.in_ready;
    assign if_b.in_valid = vld[1];
    assign if_b.in_data  = dat[1];
    assign rdy[1]        = if_b.in_ready;
    assign if_c.in_valid = vld[2];
    assign if_c.in_data  = dat[2];
    assign rdy[2]        = if_c.in_ready;

    p2s_stream #(.DATA_W(DW), .MSB_FIRST(1), .GAP_TICKS(0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .in_if(if_a.slave),
        .ser_out(so[0]), .ser_en(en[0]), .frame_start(fs[0]), .frame_last(fl[0]), .busy(bsy[0]));

    p2s_stream #(.DATA_W(DW), .MSB_FIRST(0), .GAP_TICKS(0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .in_if(if_b.slave),
        .ser_out(so[1]), .ser_en(en[1]), .frame_start(fs[1]), .frame_last(fl[1]), .busy(bsy[1]));

    p2s_stream #(.DATA_W(DW), .MSB_FIRST(1), .GAP_TICKS(3), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .tick(tick), .in_if(if_c.slave),
        .ser_out(so[2]), .ser_en(en[2]), .frame_start(fs[2]), .frame_last(fl[2]), .busy(bsy[2]));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present a word at a falling edge and return at the falling edge after it is accepted.
    task automatic send(input int u, input logic [DW-1:0] w);
        int t;
        t      = 0;
        vld[u] = 1'b1;
        dat[u] = w;
        while (rdy[u] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_val("send_ready_timeout", rdy[u], 1);
        @(negedge clk);
        vld[u] = 1'b0;
    endtask

    // Sample unit u on ncyc falling edges, starting at the current one.
    task automatic capture(input int u, input int ncyc);
        logic prev;
        cap_n = 0; cap_bits = '0; cap_fs = '0; cap_fl = '0; cap_rdyfs = '0; cap_unstable = 0;
        prev  = so[u];
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            if (en[u] === 1'b1) begin
                if (cap_n < 64) begin
                    cap_bits       = {cap_bits[62:0], so[u]};
                    cap_fs[cap_n]  = fs[u];
                    cap_fl[cap_n]  = fl[u];
                    cap_rdyfs[cap_n] = fs[u] & rdy[u];
                    cap_cyc[cap_n] = i;
                end
                cap_n++;
            end else if (so[u] !== prev && cap_n > 0 && cap_n < DW) begin
                cap_unstable++;
            end
            prev = so[u];
        end
    endtask

    initial begin
        tick    = 1'b1;
        tick_ph = 0;
        forever begin
            @(negedge clk);
            if (tick_div <= 1) begin
                tick    = 1'b1;
                tick_ph = 0;
            end else begin
                tick    = (tick_ph == 0);
                tick_ph = (tick_ph + 1) % tick_div;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        int bad;
        n_chk = 0; n_fail = 0;
        rst = 1'b1; vld = '0;
        for (int u = 0; u < 3; u++) dat[u] = '0;
        repeat (3) @(negedge clk);

        for (int u = 0; u < 3; u++) begin
            check_val($sformatf("rst_ser_out%0d", u), so[u], idle_lvl[u]);
            check_val($sformatf("rst_ser_en%0d", u), en[u], 0);
            check_val($sformatf("rst_frame%0d", u), {fs[u], fl[u]}, 0);
            check_val($sformatf("rst_busy%0d", u), bsy[u], 0);
            check_val($sformatf("rst_ready%0d", u), rdy[u], 1);
        end
        rst = 1'b0;
        @(negedge clk);

        // single MSB-first word
        send(0, 8'hA5);
        check_val("t1_busy_held", bsy[0], 1);
        check_val("t1_no_bit_yet", en[0], 0);
        capture(0, 12);
        check_val("t1_count", cap_n, 8);
        check_val("t1_bits", cap_bits[7:0], 8'hA5);
        check_val("t1_start", cap_fs, 64'h01);
        check_val("t1_last", cap_fl, 64'h80);
        check_val("t1_latency", cap_cyc[0], 1);
        check_val("t1_contig", cap_cyc[7] - cap_cyc[0], 7);
        check_val("t1_idle_level", so[0], 0);
        check_val("t1_busy_done", bsy[0], 0);

        // LSB-first order, idle level 1
        send(1, 8'h01);
        capture(1, 12);
        check_val("t2_count", cap_n, 8);
        check_val("t2_bits_01", cap_bits[7:0], 8'h80);
        check_val("t2_idle_level", so[1], 1);
        send(1, 8'h12);
        capture(1, 12);
        check_val("t2_bits_12", cap_bits[7:0], 8'h48);
        send(1, 8'hA5);
        capture(1, 12);
        check_val("t2_bits_a5", cap_bits[7:0], 8'hA5);

        // back-to-back, no gap
        fork
            begin send(0, 8'hFF); send(0, 8'h00); end
            capture(0, 24);
        join
        check_val("t3_count", cap_n, 16);
        check_val("t3_bits", cap_bits[15:0], 16'hFF00);
        check_val("t3_start", cap_fs, 64'h0101);
        check_val("t3_last", cap_fl, 64'h8080);
        check_val("t3_ready_at_pop", cap_rdyfs, 64'h0101);
        check_val("t3_contig", cap_cyc[15] - cap_cyc[0], 15);

        // three gap ticks between frames
        fork
            begin send(2, 8'h96); send(2, 8'h5A); end
            capture(2, 26);
        join
        check_val("t4_count", cap_n, 16);
        check_val("t4_bits", cap_bits[15:0], 16'h965A);
        check_val("t4_start", cap_fs, 64'h0101);
        check_val("t4_last", cap_fl, 64'h8080);
        check_val("t4_gap", cap_cyc[8] - cap_cyc[7], 4);
        check_val("t4_busy_done", bsy[2], 0);

        // tick every 4th clock
        tick_div = 4;
        send(0, 8'hC3);
        capture(0, 48);
        check_val("t5_count", cap_n, 8);
        check_val("t5_bits", cap_bits[7:0], 8'hC3);
        check_val("t5_span", cap_cyc[7] - cap_cyc[0], 28);
        bad = 0;
        for (int i = 1; i < cap_n && i < 64; i++)
            if (cap_cyc[i] - cap_cyc[i-1] != 4) bad++;
        check_val("t5_spacing", bad, 0);
        check_val("t5_stable", cap_unstable, 0);
        tick_div = 1;
        repeat (2) @(negedge clk);

        // reset mid-frame with a word held
        fork
            begin send(0, 8'hF0); send(0, 8'h0F); end
            capture(0, 6);
        join
        check_val("t6_bits_before", cap_n, 4);
        check_val("t6_word_held", rdy[0], 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_ser_out", so[0], 0);
        check_val("t6_rst_ser_en", en[0], 0);
        check_val("t6_rst_frame", {fs[0], fl[0]}, 0);
        check_val("t6_rst_busy", bsy[0], 0);
        check_val("t6_rst_ready", rdy[0], 1);
        rst = 1'b0;
        capture(0, 12);
        check_val("t6_no_resume", cap_n, 0);
        send(0, 8'h3C);
        capture(0, 12);
        check_val("t6_new_count", cap_n, 8);
        check_val("t6_new_bits", cap_bits[7:0], 8'h3C);
        check_val("t6_new_start", cap_fs, 64'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
